// File: rtl/rr_arbiter_hold_pkg.sv
// rtl/rr_arbiter_hold_pkg.sv - shared state encoding and index helper for the round-robin arbiter
package rr_arbiter_hold_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_GRANT = GRANT;

    // Callers zero-extend their one-hot vector to 64 bits and narrow the result.
    function automatic int onehot_to_idx(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// rtl/rr_arbiter_hold_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter_hold_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           preempt;

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_id, preempt
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_id, preempt
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - wrap-around priority pick starting at ptr
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner
);

    logic [2*N-1:0] mask;
    logic [2*N-1:0] cand;

    // The upper copy of req supplies the wrapped-around channels below ptr.
    always_comb begin
        mask   = {(2*N){1'b1}} << ptr;
        cand   = {req, req} & mask;
        found  = |req;
        winner = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (cand[j]) winner = (j >= N) ? IDW'(j - N) : IDW'(j);
        end
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// rtl/rr_arbiter_hold.sv - N-way round-robin arbiter with grant hold and starvation timeout
module rr_arbiter_hold
    import rr_arbiter_hold_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_hold_if.slave bus
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;
    logic [N-1:0]   gnt_r;
    logic           preempt_r;

    logic [IDW-1:0] owner;
    logic [IDW-1:0] owner_next;
    logic           owner_req;
    logic           release_ev;
    logic           timeout_ev;
    logic [IDW-1:0] pick_ptr;
    logic           found;
    logic [IDW-1:0] winner;
    logic [N-1:0]   winner_oh;

    assign owner      = IDW'(onehot_to_idx(64'(gnt_r)));
    assign owner_next = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
    assign owner_req  = bus.req[owner];
    assign release_ev = (state == ST_GRANT) && !owner_req;
    assign timeout_ev = (state == ST_GRANT) && owner_req && (MAX_HOLD > 0) && (hold_cnt == HOLD_MAX);

    // On a hand-off the search already starts after the outgoing owner, so there is no idle bubble.
    assign pick_ptr  = (release_ev || timeout_ev) ? owner_next : ptr;
    assign winner_oh = N'(1) << winner;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_r     <= '0;
            preempt_r <= 1'b0;
        end else begin
            preempt_r <= 1'b0;
            if (state == ST_IDLE) begin
                if (found) begin
                    gnt_r    <= winner_oh;
                    hold_cnt <= HOLD_ONE;
                    state    <= ST_GRANT;
                end
            end else if (release_ev || timeout_ev) begin
                ptr       <= owner_next;
                preempt_r <= timeout_ev;
                if (found) begin
                    gnt_r    <= winner_oh;
                    hold_cnt <= HOLD_ONE;
                end else begin
                    gnt_r    <= '0;
                    hold_cnt <= '0;
                    state    <= ST_IDLE;
                end
            end else if ((MAX_HOLD > 0) && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = |gnt_r;
    assign bus.gnt_id    = owner;
    assign bus.preempt   = preempt_r;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// tb/tb_rr_arbiter_hold.sv - directed self-checking bench for rr_arbiter_hold (N=4, MAX_HOLD=4)
module tb_rr_arbiter_hold;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_id;
    int   exp_pre;
    logic [3:0] r;

    rr_arbiter_hold_if #(.N(4)) bus ();

    rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        bus.req = 4'b0000;
        #12;

        // idle after reset
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_pre", 32'(bus.preempt), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_gnt", 32'(bus.gnt), 32'h0);
            check("idle_valid", 32'(bus.gnt_valid), 32'h0);
            check("idle_id", 32'(bus.gnt_id), 32'h0);
            check("idle_pre", 32'(bus.preempt), 32'h0);
        end

        // all request; each owner drops its request for one cycle
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_valid", 32'(bus.gnt_valid), 32'h1);
            check("rr_id", 32'(bus.gnt_id), 32'(g % 4));
            r = 4'b1111;
            r[bus.gnt_id] = 1'b0;
            bus.req = r;
        end

        // sole requester: periodic preempt, same owner
        do_reset();
        bus.req = 4'b0100;
        tick();
        check("solo_gnt", 32'(bus.gnt), 32'h4);
        check("solo_pre0", 32'(bus.preempt), 32'h0);
        for (int t = 2; t <= 13; t++) begin
            tick();
            exp_pre = ((t - 1) % 4 == 0) ? 1 : 0;
            check("solo_id", 32'(bus.gnt_id), 32'h2);
            check("solo_pre", 32'(bus.preempt), 32'(exp_pre));
        end

        // two requesters: alternate every 4 cycles
        do_reset();
        bus.req = 4'b0101;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_id  = (((t - 1) / 4) % 2 == 0) ? 0 : 2;
            exp_pre = (t > 1 && (t - 1) % 4 == 0) ? 1 : 0;
            check("alt_id", 32'(bus.gnt_id), 32'(exp_id));
            check("alt_pre", 32'(bus.preempt), 32'(exp_pre));
        end

        // asynchronous reset while channel 3 owns
        do_reset();
        bus.req = 4'b1000;
        tick();
        check("pre_rst_id", 32'(bus.gnt_id), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("async_gnt", 32'(bus.gnt), 32'h0);
        check("async_valid", 32'(bus.gnt_valid), 32'h0);
        bus.req = 4'b1010;
        tick();
        #2;
        reset = 1'b0;
        tick();
        check("post_rst_id", 32'(bus.gnt_id), 32'h1);

        // owner 1 releases as 3 and 0 arrive: search starts at 2
        do_reset();
        bus.req = 4'b0010;
        tick();
        check("hand_own", 32'(bus.gnt_id), 32'h1);
        bus.req = 4'b1001;
        tick();
        check("hand_id", 32'(bus.gnt_id), 32'h3);
        check("hand_gnt", 32'(bus.gnt), 32'h8);
        check("hand_pre", 32'(bus.preempt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
